apb_arb_master: RTL and testbench
=================================

# apb_arb_master

Two-port APB master with round-robin arbitration that lets two on-chip requesters share the two APB memory slaves. Each request is accepted on a valid/ready handshake. The block decodes the target slave from the address MSB, runs the APB SETUP/ACCESS sequence, and returns read data with an error flag on a one-cycle response strobe. It sits between the requesters and the slave pair (Slave_1, Slave_2), one instance per APB segment.

## Interface
- ADD_WIDTH, 9: requester address width; bit ADD_WIDTH-1 selects the slave, bits ADD_WIDTH-2:0 go to Paddr
- WIDTH, 32: data width; strobe width is WIDTH/8
- TIMEOUT, 16: maximum ACCESS cycles without Pready before the transfer is aborted (TIMEOUT ≥ 1)

Ports:
- Pclk  in  1  clock; one clock domain
- Presetn  in  1  reset; synchronous, active-low
- mN_valid  in  1  requester N (N = 0, 1) has a request
- mN_ready  out  1  request N accepted this cycle
- mN_write  in  1  1 = write, 0 = read
- mN_addr  in  ADD_WIDTH  byte-unit word address
- mN_wdata  in  WIDTH  write data
- mN_strb  in  WIDTH/8  write byte strobes
- mN_rsp_valid  out  1  one-cycle response strobe for requester N
- rsp_rdata  out  WIDTH  read data, shared; valid with mN_rsp_valid
- rsp_err  out  1  timeout flag, shared; valid with mN_rsp_valid
- Psel1, Psel2  out  1  slave selects
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Pstrb  out  WIDTH/8  APB strobes
- Paddr  out  ADD_WIDTH-1  slave word address
- Pwdata  out  WIDTH  APB write data
- Prdata1, Prdata2  in  WIDTH  slave read data
- Pready1, Pready2  in  1  slave ready

## Operation
- FSM states: IDLE → SETUP → ACCESS → RESP → IDLE.
- IDLE:
  - If any mN_valid is high, grant one requester, pulse its mN_ready, and latch write/addr/wdata/strb plus the grant ID.
  - If no requester is valid, stay in IDLE.
- Round-robin: when both requesters are valid, grant the one not granted last. After reset, the last-grant register is 1, so m0 wins the first tie.
- Requesters hold valid and all payload stable until ready. A requester may drop valid before it is granted; that is not an error.
- SETUP: the decoded Psel is 1 and Penable is 0. Psel1 is driven when addr[ADD_WIDTH-1] = 0; Psel2 when it is 1.
- ACCESS:
  - Psel stays 1 and Penable is 1.
  - The block waits on the Pready of the selected slave and ignores the other slave's Pready.
  - A timeout counter increments each ACCESS cycle. When the count reaches TIMEOUT with Pready still low, the block leaves ACCESS with the error flagged.
- RESP:
  - All P-outputs are 0; mN_rsp_valid is pulsed for the granted requester.
  - For a read, rsp_rdata is the Prdata of the selected slave, sampled in this cycle. The slaves register read data at the ACCESS edge, so it is valid only in this cycle.
  - For a write, or on timeout, rsp_rdata is 0.
  - rsp_err is 1 only on timeout.
- APB address, data, strobe and write outputs stay stable from SETUP through the end of ACCESS.

## Timing
- Reset values: every output is 0 (Psel1/2, Penable, Pwrite, Pstrb, Paddr, Pwdata, mN_ready, mN_rsp_valid, rsp_rdata, rsp_err). The FSM is in IDLE and the timeout counter is 0.
- Handshake at cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2 (1 cycle with zero-wait slaves) → RESP in cycle 3 → IDLE in cycle 4, where a new grant is possible.
- Peak throughput is 1 transfer per 4 cycles. Each additional wait state adds 1 cycle.
- A timeout occupies exactly TIMEOUT ACCESS cycles, then RESP.
- mN_ready and mN_rsp_valid are single-cycle pulses and are never asserted for both requesters in the same cycle.
- Reset asserted mid-transfer: at the next edge the FSM returns to IDLE, all outputs go to 0, the in-flight request is dropped, and no response is issued.
- Simultaneous new request and RESP: the request is not granted until IDLE.

## Structure
- Shared package/header apb_pkg: FSM state encoding (2-bit IDLE/SETUP/ACCESS/RESP), default ADD_WIDTH/WIDTH, and the slave-select bit position.
- One sub-module, rr_arb2: 2-request round-robin arbiter with a registered last-grant bit and an update-on-grant input.
- Timeout counter width is $clog2(TIMEOUT+1).

## Test plan
- Single write then read: m0 writes 0xDEADBEEF with strb 0xF to addr 0x005, then reads it back → Psel1 is set, Paddr = 0x05, and the read response shows rsp_rdata = 0xDEADBEEF, rsp_err = 0, 4 cycles per transfer.
- Slave decode: m1 writes 0x12345678 to addr 0x105, then m0 reads 0x105 → Psel2 is set with Paddr = 0x05, rdata = 0x12345678, and slave 1 is untouched.
- Fairness: both requesters hold valid continuously for 6 transfers → grants alternate m0, m1, m0 … starting with m0 after reset.
- Partial strobe: write 0xAABBCCDD with strb 0x5 over a word holding 0 → readback is 0x00BB00DD.
- Timeout: a stub slave holds Pready low with TIMEOUT = 4 → exactly 4 ACCESS cycles, then rsp_err = 1 and rsp_rdata = 0.
- Reset during ACCESS: Presetn is low for 1 cycle → all outputs are 0 at the next edge, no rsp_valid is issued, and the next request is served normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the two-port APB master: FSM encoding, default widths
// and the position of the slave-select address bit.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int DEF_ADD_WIDTH = 9;
    localparam int DEF_WIDTH     = 32;

    // The address MSB picks Slave_1 (0) or Slave_2 (1).
    function automatic int sel_bit_pos(input int add_width);
        return add_width - 1;
    endfunction

endpackage

// File: rtl/apb_arb_master_rr_arb2.sv
// Two-request round-robin arbiter; the last-grant bit only moves when a grant
// is actually taken.
module rr_arb2 (
    input  logic       Pclk,
    input  logic       Presetn,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_reg;

    // On a tie the requester that was not granted last wins.
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt[gi] = req[gi] & (~req[1-gi] | (last_reg != 1'(gi)));
    end

    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            last_reg <= 1'b1;
        end else if (update) begin
            last_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Two-port APB master: arbitrates two requesters onto a pair of APB slaves and
// returns one response strobe per accepted request.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADD_WIDTH = DEF_ADD_WIDTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int TIMEOUT   = 16
) (
    input  logic                   Pclk,
    input  logic                   Presetn,
    input  logic                   m0_valid,
    output logic                   m0_ready,
    input  logic                   m0_write,
    input  logic [ADD_WIDTH-1:0]   m0_addr,
    input  logic [WIDTH-1:0]       m0_wdata,
    input  logic [WIDTH/8-1:0]     m0_strb,
    output logic                   m0_rsp_valid,
    input  logic                   m1_valid,
    output logic                   m1_ready,
    input  logic                   m1_write,
    input  logic [ADD_WIDTH-1:0]   m1_addr,
    input  logic [WIDTH-1:0]       m1_wdata,
    input  logic [WIDTH/8-1:0]     m1_strb,
    output logic                   m1_rsp_valid,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic                   rsp_err,
    output logic                   Psel1,
    output logic                   Psel2,
    output logic                   Penable,
    output logic                   Pwrite,
    output logic [WIDTH/8-1:0]     Pstrb,
    output logic [ADD_WIDTH-2:0]   Paddr,
    output logic [WIDTH-1:0]       Pwdata,
    input  logic [WIDTH-1:0]       Prdata1,
    input  logic [WIDTH-1:0]       Prdata2,
    input  logic                   Pready1,
    input  logic                   Pready2
);

    localparam int STRB_W  = WIDTH / 8;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int SEL_BIT = sel_bit_pos(ADD_WIDTH);

    apb_state_e             state_reg;
    logic [CNT_W-1:0]       tmo_cnt_reg;
    logic                   gnt_id_reg;
    logic                   sel2_reg;
    logic                   write_reg;
    logic                   err_reg;
    logic [1:0]             rsp_valid_reg;
    logic                   psel1_reg;
    logic                   psel2_reg;
    logic                   penable_reg;
    logic                   pwrite_reg;
    logic [STRB_W-1:0]      pstrb_reg;
    logic [ADD_WIDTH-2:0]   paddr_reg;
    logic [WIDTH-1:0]       pwdata_reg;

    logic [1:0]             req;
    logic [1:0]             gnt;
    logic                   gnt_id;
    logic                   g_write;
    logic [ADD_WIDTH-1:0]   g_addr;
    logic [WIDTH-1:0]       g_wdata;
    logic [STRB_W-1:0]      g_strb;
    logic                   pready_sel;
    logic                   tmo_hit;

    // Requests are only visible to the arbiter in IDLE and outside reset, so
    // ready can never pulse during a transfer or while reset is held.
    assign req = (state_reg == ST_IDLE && Presetn) ? {m1_valid, m0_valid} : 2'b00;

    rr_arb2 u_arb (
        .Pclk    (Pclk),
        .Presetn (Presetn),
        .req     (req),
        .update  (|gnt),
        .gnt     (gnt)
    );

    assign m0_ready = gnt[0];
    assign m1_ready = gnt[1];

    assign gnt_id  = gnt[1];
    assign g_write = gnt_id ? m1_write : m0_write;
    assign g_addr  = gnt_id ? m1_addr  : m0_addr;
    assign g_wdata = gnt_id ? m1_wdata : m0_wdata;
    assign g_strb  = gnt_id ? m1_strb  : m0_strb;

    assign pready_sel = sel2_reg ? Pready2 : Pready1;
    assign tmo_hit    = (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Pclk) begin
        if (!Presetn) begin
            state_reg     <= ST_IDLE;
            tmo_cnt_reg   <= '0;
            gnt_id_reg    <= 1'b0;
            sel2_reg      <= 1'b0;
            write_reg     <= 1'b0;
            err_reg       <= 1'b0;
            rsp_valid_reg <= 2'b00;
            psel1_reg     <= 1'b0;
            psel2_reg     <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            pstrb_reg     <= '0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
        end else begin
            rsp_valid_reg <= 2'b00;
            case (state_reg)
                ST_IDLE: begin
                    if (|gnt) begin
                        gnt_id_reg <= gnt_id;
                        write_reg  <= g_write;
                        sel2_reg   <= g_addr[SEL_BIT];
                        psel1_reg  <= ~g_addr[SEL_BIT];
                        psel2_reg  <= g_addr[SEL_BIT];
                        pwrite_reg <= g_write;
                        pstrb_reg  <= g_strb;
                        paddr_reg  <= g_addr[ADD_WIDTH-2:0];
                        pwdata_reg <= g_wdata;
                        err_reg    <= 1'b0;
                        state_reg  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // The count hitting TIMEOUT ends the transfer even if the
                    // slave never answers; the response then carries the error.
                    if (pready_sel || tmo_hit) begin
                        psel1_reg     <= 1'b0;
                        psel2_reg     <= 1'b0;
                        penable_reg   <= 1'b0;
                        pwrite_reg    <= 1'b0;
                        pstrb_reg     <= '0;
                        paddr_reg     <= '0;
                        pwdata_reg    <= '0;
                        err_reg       <= ~pready_sel;
                        rsp_valid_reg[gnt_id_reg] <= 1'b1;
                        tmo_cnt_reg   <= '0;
                        state_reg     <= ST_RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    err_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_rsp_valid = rsp_valid_reg[0];
    assign m1_rsp_valid = rsp_valid_reg[1];
    assign rsp_err      = err_reg;

    // Slaves present read data for exactly the RESP cycle, so it is passed
    // straight through rather than registered.
    assign rsp_rdata = (state_reg == ST_RESP && !write_reg && !err_reg)
                     ? (sel2_reg ? Prdata2 : Prdata1) : '0;

    assign Psel1   = psel1_reg;
    assign Psel2   = psel2_reg;
    assign Penable = penable_reg;
    assign Pwrite  = pwrite_reg;
    assign Pstrb   = pstrb_reg;
    assign Paddr   = paddr_reg;
    assign Pwdata  = pwdata_reg;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: two memory slave stubs, a transaction-timeline
// reference model checked every cycle, and directed transfers.
module tb_apb_arb_master;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          Pclk = 1'b0;
    logic          Presetn;
    logic          m0_valid, m0_ready, m0_write, m0_rsp_valid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [SW-1:0] m0_strb;
    logic          m1_valid, m1_ready, m1_write, m1_rsp_valid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [SW-1:0] m1_strb;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          Psel1, Psel2, Penable, Pwrite;
    logic [SW-1:0] Pstrb;
    logic [AW-2:0] Paddr;
    logic [DW-1:0] Pwdata;
    logic [DW-1:0] Prdata1, Prdata2;
    logic          Pready1, Pready2;

    always #5 Pclk = ~Pclk;

    apb_arb_master #(.ADD_WIDTH(AW), .WIDTH(DW), .TIMEOUT(TO)) dut (
        .Pclk(Pclk), .Presetn(Presetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_strb(m0_strb),
        .m0_rsp_valid(m0_rsp_valid),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_strb(m1_strb),
        .m1_rsp_valid(m1_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Psel1(Psel1), .Psel2(Psel2), .Penable(Penable), .Pwrite(Pwrite),
        .Pstrb(Pstrb), .Paddr(Paddr), .Pwdata(Pwdata),
        .Prdata1(Prdata1), .Prdata2(Prdata2),
        .Pready1(Pready1), .Pready2(Pready2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge Pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- slave stubs (wait states / hang configurable) -------
    int            ws1 = 0, ws2 = 0, acc1 = 0, acc2 = 0;
    bit            hang1 = 0, hang2 = 0;
    logic [DW-1:0] mem1 [0:255];
    logic [DW-1:0] mem2 [0:255];

    assign Pready1 = Psel1 && Penable && (acc1 >= ws1) && !hang1;
    assign Pready2 = Psel2 && Penable && (acc2 >= ws2) && !hang2;

    always @(posedge Pclk) begin
        acc1 <= (Psel1 && Penable) ? acc1 + 1 : 0;
        acc2 <= (Psel2 && Penable) ? acc2 + 1 : 0;
        if (Pready1) begin
            if (Pwrite) begin
                for (int b = 0; b < SW; b++)
                    if (Pstrb[b]) mem1[Paddr][8*b +: 8] <= Pwdata[8*b +: 8];
            end else Prdata1 <= mem1[Paddr];
        end
        if (Pready2) begin
            if (Pwrite) begin
                for (int b = 0; b < SW; b++)
                    if (Pstrb[b]) mem2[Paddr][8*b +: 8] <= Pwdata[8*b +: 8];
            end else Prdata2 <= mem2[Paddr];
        end
    end

    // ---------------- reference model ------------------------------------
    // One transfer = grant cycle, one SETUP cycle, len ACCESS cycles, one
    // RESP cycle; memory is a flat 512-word array over both slaves.
    bit            model_on = 0;
    bit            m_busy = 0;
    int            m_gcyc, m_id, m_len, m_last = 1, off, gid, wsel;
    bit            m_write, m_tmo, resp_now, gnt_now, hsel;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    logic [DW-1:0] exp_mem [0:511];

    logic [1:0]    e_rdy, e_rv;
    logic          e_psel1, e_psel2, e_pen, e_pwrite, e_err;
    logic [SW-1:0] e_pstrb;
    logic [AW-2:0] e_paddr;
    logic [DW-1:0] e_pwdata, e_rdata;

    int            gnt_id_q[$];
    int            gnt_cyc_q[$];
    logic [DW-1:0] rsp_data_q[$];
    logic          rsp_err_q[$];
    int            rsp_acc_q[$];
    int            pen_cnt = 0;

    always @(negedge Pclk) begin
        if (model_on) begin
            if (!Presetn) begin
                chk("rst_no_rsp", {m1_rsp_valid, m0_rsp_valid}, 2'b00);
                m_busy = 0;
                m_last = 1;
            end else begin
                e_rdy = 0; e_rv = 0; e_psel1 = 0; e_psel2 = 0; e_pen = 0;
                e_pwrite = 0; e_err = 0; e_pstrb = 0; e_paddr = 0;
                e_pwdata = 0; e_rdata = 0; resp_now = 0; gnt_now = 0; gid = 0;
                if (m_busy) begin
                    off = cyc - m_gcyc;
                    if (off >= 1 && off <= 1 + m_len) begin
                        e_psel1 = !m_addr[AW-1];
                        e_psel2 = m_addr[AW-1];
                        e_pen = (off >= 2);
                        e_pwrite = m_write;
                        e_pstrb = m_strb;
                        e_paddr = m_addr[AW-2:0];
                        e_pwdata = m_wdata;
                    end else if (off == 2 + m_len) begin
                        e_rv[m_id] = 1'b1;
                        e_err = m_tmo;
                        e_rdata = (!m_write && !m_tmo) ? exp_mem[m_addr] : '0;
                        resp_now = 1;
                    end
                end else if (m0_valid || m1_valid) begin
                    if (m0_valid && m1_valid) gid = (m_last == 1) ? 0 : 1;
                    else gid = m1_valid ? 1 : 0;
                    e_rdy[gid] = 1'b1;
                    gnt_now = 1;
                end
                chk("m0_ready", m0_ready, e_rdy[0]);
                chk("m1_ready", m1_ready, e_rdy[1]);
                chk("Psel1", Psel1, e_psel1);
                chk("Psel2", Psel2, e_psel2);
                chk("Penable", Penable, e_pen);
                chk("Pwrite", Pwrite, e_pwrite);
                chk("Pstrb", Pstrb, e_pstrb);
                chk("Paddr", Paddr, e_paddr);
                chk("Pwdata", Pwdata, e_pwdata);
                chk("m0_rsp_valid", m0_rsp_valid, e_rv[0]);
                chk("m1_rsp_valid", m1_rsp_valid, e_rv[1]);
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_err", rsp_err, e_err);
                // log what the DUT actually did for the directed checks
                if (m0_ready || m1_ready) begin
                    gnt_id_q.push_back(m1_ready ? 1 : 0);
                    gnt_cyc_q.push_back(cyc);
                    pen_cnt = 0;
                end
                if (Penable) pen_cnt++;
                if (m0_rsp_valid || m1_rsp_valid) begin
                    rsp_data_q.push_back(rsp_rdata);
                    rsp_err_q.push_back(rsp_err);
                    rsp_acc_q.push_back(pen_cnt);
                end
                if (resp_now) begin
                    if (m_write && !m_tmo)
                        for (int b = 0; b < SW; b++)
                            if (m_strb[b]) exp_mem[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
                    m_busy = 0;
                end
                if (gnt_now) begin
                    m_busy = 1; m_gcyc = cyc; m_id = gid; m_last = gid;
                    m_write = gid ? m1_write : m0_write;
                    m_addr  = gid ? m1_addr  : m0_addr;
                    m_wdata = gid ? m1_wdata : m0_wdata;
                    m_strb  = gid ? m1_strb  : m0_strb;
                    wsel = m_addr[AW-1] ? ws2 : ws1;
                    hsel = m_addr[AW-1] ? hang2 : hang1;
                    m_tmo = hsel || (wsel + 1 > TO);
                    m_len = m_tmo ? TO : wsel + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic req(input int id, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n = 0;
        bit got = 0;
        if (id == 0) begin
            m0_write = wr; m0_addr = a; m0_wdata = d; m0_strb = s; m0_valid = 1;
        end else begin
            m1_write = wr; m1_addr = a; m1_wdata = d; m1_strb = s; m1_valid = 1;
        end
        while (!got && n < 60) begin
            @(negedge Pclk);
            got = (id == 0) ? m0_ready : m1_ready;
            n++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL req_handshake m%0d: no ready within %0d cycles, required ready", id, n);
        end
        @(posedge Pclk); #1;
        if (id == 0) m0_valid = 0; else m1_valid = 0;
    endtask

    task automatic wait_rsps(input int total);
        int n = 0;
        while (rsp_data_q.size() < total && n < 200) begin
            @(negedge Pclk);
            n++;
        end
        if (rsp_data_q.size() < total) begin
            checks++; errors++;
            $display("FAIL rsp_wait: got %0d responses required %0d", rsp_data_q.size(), total);
        end
        @(posedge Pclk); #1;
    endtask

    task automatic xfer(input int id, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n0 = rsp_data_q.size();
        req(id, wr, a, d, s);
        wait_rsps(n0 + 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {m1_ready, m0_ready}, 2'b00);
        chk({tag, "_rsp_valid"}, {m1_rsp_valid, m0_rsp_valid}, 2'b00);
        chk({tag, "_psel"}, {Psel2, Psel1}, 2'b00);
        chk({tag, "_penable"}, Penable, 1'b0);
        chk({tag, "_pwrite"}, Pwrite, 1'b0);
        chk({tag, "_pstrb"}, Pstrb, 4'h0);
        chk({tag, "_paddr"}, Paddr, 8'h00);
        chk({tag, "_pwdata"}, Pwdata, 32'h0);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_err"}, rsp_err, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int gbase, nrsp;
        for (int i = 0; i < 256; i++) begin mem1[i] = '0; mem2[i] = '0; end
        for (int i = 0; i < 512; i++) exp_mem[i] = '0;
        Prdata1 = '0; Prdata2 = '0;
        m0_valid = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0; m0_strb = '0;
        m1_valid = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0; m1_strb = '0;
        Presetn = 0;
        repeat (3) @(posedge Pclk);
        #1;
        chk_all_zero("reset");
        Presetn = 1;
        model_on = 1;
        @(posedge Pclk); #1;

        // write then read back on slave 1
        xfer(0, 1, 9'h005, 32'hDEADBEEF, 4'hF);
        xfer(0, 0, 9'h005, 32'h0, 4'h0);
        chk("wr_rd_rdata", rsp_data_q[$], 32'hDEADBEEF);
        chk("wr_rd_err", rsp_err_q[$], 1'b0);
        chk("wr_rd_access_cycles", rsp_acc_q[$], 1);

        // slave decode through the address MSB
        xfer(1, 1, 9'h105, 32'h12345678, 4'hF);
        xfer(0, 0, 9'h105, 32'h0, 4'h0);
        chk("decode_rdata", rsp_data_q[$], 32'h12345678);
        chk("decode_slave1_untouched", mem1[5], 32'hDEADBEEF);
        chk("decode_slave2_word", mem2[5], 32'h12345678);

        // fairness from a fresh reset: both hold valid for 6 transfers
        Presetn = 0;
        @(posedge Pclk); #1;
        Presetn = 1;
        gbase = gnt_id_q.size();
        nrsp = rsp_data_q.size();
        fork
            begin
                for (int i = 0; i < 3; i++) req(0, 1, 9'(9'h110 + i), 32'(32'hA0 + i), 4'hF);
            end
            begin
                for (int i = 0; i < 3; i++) req(1, 1, 9'(9'h120 + i), 32'(32'hB0 + i), 4'hF);
            end
        join
        wait_rsps(nrsp + 6);
        for (int k = 0; k < 6; k++) begin
            chk("fair_grant_id", gnt_id_q[gbase + k], k % 2);
            if (k > 0) chk("fair_grant_spacing", gnt_cyc_q[gbase + k] - gnt_cyc_q[gbase + k - 1], 4);
        end

        // partial strobe over a zeroed word
        xfer(0, 1, 9'h020, 32'h0, 4'hF);
        xfer(0, 1, 9'h020, 32'hAABBCCDD, 4'h5);
        xfer(0, 0, 9'h020, 32'h0, 4'h0);
        chk("strobe_rdata", rsp_data_q[$], 32'h00BB00DD);

        // two wait states on slave 1
        ws1 = 2;
        xfer(1, 0, 9'h020, 32'h0, 4'h0);
        chk("wait_rdata", rsp_data_q[$], 32'h00BB00DD);
        chk("wait_access_cycles", rsp_acc_q[$], 3);
        ws1 = 0;

        // slave 2 never answers
        hang2 = 1;
        xfer(1, 0, 9'h1FF, 32'h0, 4'h0);
        chk("timeout_err", rsp_err_q[$], 1'b1);
        chk("timeout_rdata", rsp_data_q[$], 32'h0);
        chk("timeout_access_cycles", rsp_acc_q[$], TO);
        hang2 = 0;

        // reset pulse during ACCESS drops the in-flight write
        ws1 = 3;
        req(0, 1, 9'h030, 32'h00000077, 4'hF);
        @(posedge Pclk); #1;
        chk("rst_mid_in_access", Penable, 1'b1);
        nrsp = rsp_data_q.size();
        Presetn = 0;
        @(posedge Pclk); #1;
        Presetn = 1;
        chk_all_zero("rst_mid");
        repeat (8) @(posedge Pclk);
        #1;
        chk("rst_mid_no_response", rsp_data_q.size(), nrsp);
        ws1 = 0;
        xfer(0, 0, 9'h030, 32'h0, 4'h0);
        chk("rst_mid_write_dropped", rsp_data_q[$], 32'h0);
        xfer(1, 0, 9'h005, 32'h0, 4'h0);
        chk("rst_mid_then_read", rsp_data_q[$], 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
